// File: rtl/r2r_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : r2r_seq_pkg
//  Description : Shared encodings for the multi-channel R2R DAC sequencer.
//                Holds the waveform mode codes, the triangle direction type
//                and the dither LFSR constants and step function.
//                The LFSR items are only referenced when R2R_DITHER_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
package r2r_seq_pkg;

    // Waveform mode codes; code 2'b11 is reserved and behaves as HOLD.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_RAMP = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;

    // Triangle direction.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        lfsr_next = (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage : r2r_seq_pkg
`default_nettype wire

// File: rtl/r2r_seq_channel.sv
`default_nettype none
// ============================================================================
//  Module      : r2r_seq_channel
//  Description : One waveform generator (HOLD / RAMP / TRI) for a single R2R
//                ladder. Holds mode, step, triangle direction and the current
//                value. The external-data override loads the value directly
//                without touching mode, step or direction.
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                i_update       advance the generator on this edge (tick)
//                i_ext          load value from i_data on this edge
//                i_wr           write mode <= i_mode, step <= i_data, dir <= UP
//                i_mode         mode code for i_wr
//                i_data         shared data bus
//                i_dither       dither bit to add to the emitted value
//                o_value        emitted value (generator value, optionally
//                               dithered with saturation)
//  Revision    : 1.0  initial release
// ============================================================================
module r2r_seq_channel
    import r2r_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_update,
    input  logic              i_ext,
    input  logic              i_wr,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_dither,
    output logic [DATA_W-1:0] o_value
);

    localparam logic [DATA_W-1:0] c_max = '1;

    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_step;
    logic [DATA_W-1:0] r_value;
    dir_t              r_dir;
    // Set while the value came from the override; such values are emitted
    // undithered until the generator next moves.
    logic              r_from_ext;

    logic [DATA_W:0]   w_sum;
    logic              w_dither_ok;

    // One extra bit so the triangle top-end compare cannot wrap.
    assign w_sum = {1'b0, r_value} + {1'b0, r_step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MODE_HOLD;
            r_step     <= DATA_W'(1);
            r_value    <= '0;
            r_dir      <= DIR_UP;
            r_from_ext <= 1'b0;
        end else begin
            if (i_ext) begin
                r_value    <= i_data;
                r_from_ext <= 1'b1;
            end else if (i_update) begin
                r_from_ext <= 1'b0;
                // A zero step leaves everything (including dir) untouched.
                if (r_step != '0) begin
                    case (r_mode)
                        MODE_RAMP: r_value <= w_sum[DATA_W-1:0];
                        MODE_TRI: begin
                            if (r_dir == DIR_UP) begin
                                if (w_sum >= {1'b0, c_max}) begin
                                    r_value <= c_max;
                                    r_dir   <= DIR_DOWN;
                                end else begin
                                    r_value <= w_sum[DATA_W-1:0];
                                end
                            end else begin
                                if (r_value <= r_step) begin
                                    r_value <= '0;
                                    r_dir   <= DIR_UP;
                                end else begin
                                    r_value <= r_value - r_step;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Placed last so a coincident write wins the dir update; the
            // generator step above still used the old mode/step.
            if (i_wr) begin
                r_mode <= i_mode;
                r_step <= i_data;
                r_dir  <= DIR_UP;
            end
        end
    end

    assign w_dither_ok = !r_from_ext && ((r_mode == MODE_RAMP) || (r_mode == MODE_TRI));
    assign o_value     = (w_dither_ok && i_dither && (r_value != c_max))
                         ? r_value + DATA_W'(1) : r_value;

endmodule : r2r_seq_channel
`default_nettype wire

// File: rtl/r2r_dac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : r2r_dac_sequencer
//  Description : Multi-channel R2R DAC sequencer. A shared programmable
//                divider produces an update tick; NUM_CH generators advance
//                on the edge ending each tick cycle. ext_data overrides every
//                channel with the data bus.
//                Optional macro R2R_DITHER_EN adds a 16-bit Galois LFSR whose
//                bit 0 dithers the RAMP/TRI outputs (saturating at max).
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                enable          divider runs when high
//                ext_data        override all channels with data
//                load_divider    strobe: reload <= data, cnt <= 0
//                mode_wr         strobe: channel ch_sel mode/step write
//                ch_sel          channel addressed by mode_wr
//                mode            mode code for mode_wr
//                data            shared data bus
//                tick            one-cycle pulse at each update point
//                r2r_out         channel c on [c*DATA_W +: DATA_W]
//  Revision    : 1.0  initial release
// ============================================================================
module r2r_dac_sequencer
    import r2r_seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 9,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     ext_data,
    input  logic                     load_divider,
    input  logic                     mode_wr,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic [1:0]               mode,
    input  logic [DATA_W-1:0]        data,
    output logic                     tick,
    output logic [NUM_CH*DATA_W-1:0] r2r_out
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;
    logic             r_tick;
    logic             w_dither;

    // Divider: a load always wins over the wrap, so a load on the wrap edge
    // suppresses that tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_reload <= DIV_W'(DIV_RESET);
            r_tick   <= 1'b0;
        end else if (load_divider) begin
            r_reload <= DIV_W'(data);
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else if (enable) begin
            if (r_cnt == r_reload) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

`ifdef R2R_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_tick) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_dither = r_lfsr[0];
`else
    assign w_dither = 1'b0;
`endif

    // Out-of-range ch_sel values match no channel, so such writes drop.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_wr;

        assign w_wr = mode_wr && (ch_sel == SEL_W'(c));

        r2r_seq_channel #(
            .DATA_W (DATA_W)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .i_update (r_tick),
            .i_ext    (ext_data),
            .i_wr     (w_wr),
            .i_mode   (mode),
            .i_data   (data),
            .i_dither (w_dither),
            .o_value  (r2r_out[c*DATA_W +: DATA_W])
        );
    end

endmodule : r2r_dac_sequencer
`default_nettype wire
